// File: rtl/leon_dcache_responder.sv
// Data-cache responder for the LEON IU data side: wait-stated loads, byte-enable stores into a
// word array, and a registered feed of committed stores for scoreboard capture.
module leon_dcache_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  input  logic        pl_en_i,
  input  logic [31:0] pl_addr_i,
  input  logic [31:0] pl_data_i,
  output logic        hold_n_o,
  output logic        mds_n_o,
  output logic [31:0] rdata_o,
  output logic        mexc_o,
  output logic        st_valid_o,
  output logic [31:0] st_addr_o,
  output logic [31:0] st_data_o,
  output logic [15:0] st_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WaitInit = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        latch;

  logic        hold_n_q, hold_n_d;
  logic        mds_n_q, mds_n_d;
  logic        mexc_q, mexc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        st_valid_q, st_valid_d;
  logic [31:0] st_addr_q, st_addr_d;
  logic [31:0] st_data_q, st_data_d;
  logic [15:0] st_count_q, st_count_d;

  logic [31:0] mem_q [DEPTH];

  // In IDLE the live request drives the datapath so zero-wait responses need no extra cycle.
  logic          eff_write;
  logic [31:0]   eff_addr;
  logic [3:0]    eff_be;
  logic [31:0]   eff_wdata;
  logic [AW-1:0] word_idx;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [31:0]   merged;
  logic          commit;

  logic unused_pl_addr;
  assign unused_pl_addr = ^{pl_addr_i[31:AW+2], pl_addr_i[1:0]};

  always_comb begin
    eff_write = (state_q == StIdle) ? req_write_i : write_q;
    eff_addr  = (state_q == StIdle) ? req_addr_i  : addr_q;
    eff_be    = (state_q == StIdle) ? req_be_i    : be_q;
    eff_wdata = (state_q == StIdle) ? req_wdata_i : wdata_q;
    word_idx  = eff_addr[AW+1:2];
    acc_err   = (|eff_addr[31:AW+2]) | (|eff_addr[1:0]);
    rd_word   = mem_q[word_idx];
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = eff_be[b] ? eff_wdata[b*8 +: 8] : rd_word[b*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    latch   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!pl_en_i && req_valid_i) begin
          latch = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            wcnt_d  = WaitInit;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (wcnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
        commit  = eff_write & ~acc_err;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    hold_n_d = (state_d != StWait);
    mds_n_d  = (state_d != StResp);
    mexc_d   = (state_d == StResp) & acc_err;
    rdata_d  = rdata_q;
    if (state_d == StResp) begin
      rdata_d = (eff_write || acc_err) ? 32'd0 : rd_word;
    end

    st_valid_d = commit;
    st_addr_d  = commit ? addr_q : st_addr_q;
    st_data_d  = commit ? merged : st_data_q;
    st_count_d = st_count_q + {15'd0, commit};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wcnt_q     <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      hold_n_q   <= 1'b1;
      mds_n_q    <= 1'b1;
      mexc_q     <= 1'b0;
      rdata_q    <= 32'd0;
      st_valid_q <= 1'b0;
      st_addr_q  <= 32'd0;
      st_data_q  <= 32'd0;
      st_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      if (latch) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        be_q    <= req_be_i;
        wdata_q <= req_wdata_i;
      end
      hold_n_q   <= hold_n_d;
      mds_n_q    <= mds_n_d;
      mexc_q     <= mexc_d;
      rdata_q    <= rdata_d;
      st_valid_q <= st_valid_d;
      st_addr_q  <= st_addr_d;
      st_data_q  <= st_data_d;
      st_count_q <= st_count_d;
    end
  end

  // Array is deliberately not reset; reset forces IDLE, which blocks any pending commit.
  always_ff @(posedge clk_i) begin
    if (state_q == StIdle && pl_en_i) begin
      mem_q[pl_addr_i[AW+1:2]] <= pl_data_i;
    end else if (commit) begin
      mem_q[word_idx] <= merged;
    end
  end

  assign hold_n_o   = hold_n_q;
  assign mds_n_o    = mds_n_q;
  assign mexc_o     = mexc_q;
  assign rdata_o    = rdata_q;
  assign st_valid_o = st_valid_q;
  assign st_addr_o  = st_addr_q;
  assign st_data_o  = st_data_q;
  assign st_count_o = st_count_q;

endmodule

// File: doc/leon_dcache_responder.md
# leon_dcache_responder

Behavioural-synthesizable data-cache responder that answers the integer unit's data-side requests on the LEON interface testbench. It sits on the dcache side of the processor wrapper and plays the memory end of the protocol that the testbench's BFM otherwise drives by hand. It:
- returns load data with a programmable number of hold (wait-state) cycles;
- commits stores into a small word-addressed array;
- publishes every committed store for scoreboard capture.

## Interface
Parameters:
- DEPTH, 256, words in the backing array; power of 2, minimum 4.
- WAIT_STATES, 2, hold cycles inserted before each response; range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  IU data request. The IU holds it, and all req_* fields, stable until it observes mds_n=0.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; the word index is req_addr[log2(DEPTH)+1:2].
- req_be  in  4  store byte enables; bit 3 = bits 31:24.
- req_wdata  in  32  store data.
- pl_en  in  1  testbench preload strobe.
- pl_addr  in  32  preload byte address, word-aligned.
- pl_data  in  32  preload word.
- hold_n  out  1  0 = stall the IU.
- mds_n  out  1  0 = response cycle (memory data strobe).
- rdata  out  32  load data, valid when mds_n=0.
- mexc  out  1  memory exception, valid when mds_n=0.
- st_valid  out  1  one-cycle pulse per committed store.
- st_addr  out  32  byte address of the committed store.
- st_data  out  32  full merged word after the store.
- st_count  out  16  committed-store counter.

## Operation
- FSM states are IDLE, WAIT and RESP. All outputs are registered.
- **IDLE**
  - If pl_en=1, write pl_data to the array and do not accept a request in this cycle. Preload has priority; the held request is sampled on a later edge.
  - Otherwise, if req_valid=1, latch the request.
  - Next state is WAIT with wcnt=WAIT_STATES-1 when WAIT_STATES>0, else RESP.
- **WAIT**
  - hold_n=0.
  - wcnt decrements each edge. On the edge where wcnt==0, go to RESP.
  - pl_en is ignored.
- **RESP** (lasts exactly one cycle)
  - hold_n=1 and mds_n=0.
  - Load: rdata = array word.
  - Store: rdata=0. The byte-enable merge commits on the edge that leaves RESP. st_valid pulses in the cycle after RESP, with st_addr = latched address and st_data = merged word. st_count increments, wrapping 0xFFFF→0.
  - Out-of-range address (word index ≥ DEPTH): mexc=1 and rdata=0; a store is dropped, with no st_valid and no count change.
  - Misaligned address (req_addr[1:0]≠0): mexc=1, no array access.
  - Always returns to IDLE, even if req_valid is still high.
- Outside RESP: mds_n=1, mexc=0, rdata holds its last value.
- Array contents are not reset.

## Timing
- Reset values: state=IDLE, hold_n=1, mds_n=1, mexc=0, rdata=0, st_valid=0, st_addr=0, st_data=0, st_count=0.
- Load latency: a request sampled at edge E0 yields mds_n=0 in the cycle after edge E0+WAIT_STATES.
  - hold_n=0 for exactly WAIT_STATES cycles immediately before it.
  - WAIT_STATES=0 means RESP in the cycle right after E0, with no hold.
- Throughput: one transaction per WAIT_STATES+2 cycles, because the IDLE sample cycle is mandatory between back-to-back requests.
- Read-after-write to the same word returns the new data, since the write commits before the next IDLE sample.
- Reset asserted mid-transaction:
  - Outputs go to reset values immediately, asynchronously.
  - A store not yet committed is lost, with no st_valid.
  - After release, the FSM starts in IDLE.
- Preload and request asserted in the same IDLE cycle: the preload happens first. A subsequent load of the same word sees the preloaded value.

## Test plan
- **Preload then load, WAIT_STATES=2:** preload 0x10=0x00000005, then load 0x10. Required: hold_n=0 for 2 cycles, then one cycle with mds_n=0, rdata=0x00000005, mexc=0.
- **Byte-enable store:** preload 0x20=0xAABBCCDD, store 0x20 with be=4'b0011 and wdata=0x11223344. Required: st_valid pulse with st_addr=0x20, st_data=0xAABB3344, st_count=1. A following load of 0x20 returns 0xAABB3344.
- **Zero-latency back-to-back loads, WAIT_STATES=0:** req_valid held for addresses 0x0 and 0x4 (preloaded with 1 and 2). Required: hold_n stays 1, mds_n=0 every second cycle, rdata 1 then 2.
- **Out-of-range access, DEPTH=256:** store to 0x400. Required: mexc=1 with mds_n=0, no st_valid, st_count unchanged. A load of 0x400 gives mexc=1, rdata=0.
- **Reset mid-WAIT, WAIT_STATES=4:** assert rst=0 on the second WAIT cycle of a store to 0x8. Required: hold_n=1 and mds_n=1 at once, st_count=0, word 0x8 unchanged. A later load after reset completes normally.
- **Store counter wrap:** force 65536 committed stores. Required: st_count returns to 0x0000 and st_valid pulses on every store.
